// File: rtl/vga_vram_scanout.sv
// VRAM scan-out engine: bit-addressed framebuffer with byte-enabled writes, frame-shadowed
// config, modulo-wrapped scrolling, row-match pulse and a blank/frame CPU wait handshake.
module vga_vram_scanout #(
    parameter int unsigned PIXEL_COUNT = 320,
    parameter int unsigned IDX_W       = 9,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned WADDR_W     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               vram_we_i,
    input  logic [WADDR_W-1:0] vram_waddr_i,
    input  logic [31:0]        vram_wdata_i,
    input  logic [3:0]         vram_be_i,
    input  logic [23:0]        palette_i,
    input  logic               bpp2_i,
    input  logic [CNT_W-1:0]   x_rep_i,
    input  logic [CNT_W-1:0]   y_rep_i,
    input  logic [IDX_W-1:0]   stride_i,
    input  logic [IDX_W-1:0]   start_idx_i,
    input  logic [7:0]         match_row_i,
    input  logic               blank_i,
    input  logic               new_scanline_i,
    input  logic               new_frame_i,
    input  logic               wait_req_i,
    input  logic               wait_sel_i,
    output logic [5:0]         rgb_o,
    output logic [IDX_W-1:0]   vram_idx_o,
    output logic [7:0]         row_o,
    output logic               row_done_o,
    output logic               row_match_o,
    output logic               stall_o
);

    localparam int unsigned    NumWords = PIXEL_COUNT / 32;
    localparam logic [IDX_W:0] PixCnt   = (IDX_W+1)'(PIXEL_COUNT);

    logic [PIXEL_COUNT-1:0] vram_q;

    logic             bpp2_q, bpp2_d;
    logic [CNT_W-1:0] x_rep_q, x_rep_d;
    logic [CNT_W-1:0] y_rep_q, y_rep_d;
    logic [IDX_W-1:0] stride_q, stride_d;
    logic [IDX_W-1:0] start_q, start_d;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] line_base_q, line_base_d;
    logic [CNT_W-1:0] px_q, px_d;
    logic [CNT_W-1:0] py_q, py_d;
    logic [7:0]       row_q, row_d;
    logic             row_done_q, row_done_d;
    logic             row_match_q, row_match_d;
    logic [5:0]       rgb_q, rgb_d;
    logic             stall_q, stall_d;
    logic             wait_sel_q, wait_sel_d;
    logic             blank_q;

    logic [IDX_W-1:0] stride_ld, start_ld, step, next_base, idx_hi;
    logic [1:0]       ci;

    // Wrapping add; both operands are always below PIXEL_COUNT so one subtraction suffices.
    function automatic logic [IDX_W-1:0] adv(input logic [IDX_W-1:0] a,
                                             input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= PixCnt) sum = sum - PixCnt;
        return sum[IDX_W-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (vram_we_i) begin
            for (int w = 0; w < NumWords; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (vram_waddr_i == WADDR_W'(w) && vram_be_i[b]) begin
                        vram_q[32*w + 8*b +: 8] <= vram_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        stride_ld = ({1'b0, stride_i} >= PixCnt) ? '0 : stride_i;
        start_ld  = ({1'b0, start_idx_i} >= PixCnt) ? '0 : start_idx_i;
        if (bpp2_i) begin
            stride_ld[0] = 1'b0;
            start_ld[0]  = 1'b0;
        end
        step      = bpp2_q ? IDX_W'(2) : IDX_W'(1);
        next_base = adv(line_base_q, stride_q);
    end

    always_comb begin
        bpp2_d      = bpp2_q;
        x_rep_d     = x_rep_q;
        y_rep_d     = y_rep_q;
        stride_d    = stride_q;
        start_d     = start_q;
        idx_d       = idx_q;
        line_base_d = line_base_q;
        px_d        = px_q;
        py_d        = py_q;
        row_d       = row_q;
        row_done_d  = 1'b0;
        row_match_d = 1'b0;

        if (new_frame_i) begin
            bpp2_d      = bpp2_i;
            x_rep_d     = x_rep_i;
            y_rep_d     = y_rep_i;
            stride_d    = stride_ld;
            start_d     = start_ld;
            idx_d       = start_ld;
            line_base_d = start_ld;
            px_d        = '0;
            py_d        = '0;
            row_d       = '0;
        end else if (new_scanline_i) begin
            px_d = '0;
            if (py_q == y_rep_q) begin
                py_d        = '0;
                line_base_d = next_base;
                idx_d       = next_base;
                row_d       = (row_q == 8'hFF) ? row_q : row_q + 8'd1;
                row_done_d  = 1'b1;
                row_match_d = (row_d == match_row_i);
            end else begin
                py_d  = py_q + CNT_W'(1);
                idx_d = line_base_q;
            end
        end else if (blank_i) begin
            px_d = '0;
        end else if (px_q == x_rep_q) begin
            px_d  = '0;
            idx_d = adv(idx_q, step);
        end else begin
            px_d = px_q + CNT_W'(1);
        end
    end

    always_comb begin
        idx_hi = idx_q + IDX_W'(1);
        ci[0]  = vram_q[idx_q];
        ci[1]  = bpp2_q && ({1'b0, idx_hi} < PixCnt) ? vram_q[idx_hi] : 1'b0;
        rgb_d  = '0;
        if (!blank_i) begin
            unique case (ci)
                2'd0: rgb_d = palette_i[5:0];
                2'd1: rgb_d = palette_i[11:6];
                2'd2: rgb_d = palette_i[17:12];
                2'd3: rgb_d = palette_i[23:18];
            endcase
        end
    end

    // A new request always wins, so the request cycle itself can never release the wait.
    always_comb begin
        stall_d    = stall_q;
        wait_sel_d = wait_sel_q;
        if (wait_req_i) begin
            stall_d    = 1'b1;
            wait_sel_d = wait_sel_i;
        end else if (stall_q) begin
            if (!wait_sel_q && blank_i && !blank_q) stall_d = 1'b0;
            if (wait_sel_q && new_frame_i)          stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bpp2_q      <= 1'b0;
            x_rep_q     <= CNT_W'(51);
            y_rep_q     <= CNT_W'(1);
            stride_q    <= IDX_W'(20);
            start_q     <= '0;
            idx_q       <= '0;
            line_base_q <= '0;
            px_q        <= '0;
            py_q        <= '0;
            row_q       <= '0;
            row_done_q  <= 1'b0;
            row_match_q <= 1'b0;
            rgb_q       <= '0;
            stall_q     <= 1'b0;
            wait_sel_q  <= 1'b0;
            blank_q     <= 1'b0;
        end else begin
            bpp2_q      <= bpp2_d;
            x_rep_q     <= x_rep_d;
            y_rep_q     <= y_rep_d;
            stride_q    <= stride_d;
            start_q     <= start_d;
            idx_q       <= idx_d;
            line_base_q <= line_base_d;
            px_q        <= px_d;
            py_q        <= py_d;
            row_q       <= row_d;
            row_done_q  <= row_done_d;
            row_match_q <= row_match_d;
            rgb_q       <= rgb_d;
            stall_q     <= stall_d;
            wait_sel_q  <= wait_sel_d;
            blank_q     <= blank_i;
        end
    end

    assign rgb_o       = rgb_q;
    assign vram_idx_o  = idx_q;
    assign row_o       = row_q;
    assign row_done_o  = row_done_q;
    assign row_match_o = row_match_q;
    assign stall_o     = stall_q;

endmodule

// File: tb/tb_vga_vram_scanout.sv
// Directed bench for vga_vram_scanout with hand-computed expectations.
module tb_vga_vram_scanout;

    localparam logic [5:0] C0 = 6'h10;
    localparam logic [5:0] C1 = 6'h0B;
    localparam logic [5:0] C2 = 6'h2A;
    localparam logic [5:0] C3 = 6'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic        vram_we;
    logic [3:0]  vram_waddr;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_be;
    logic [23:0] palette;
    logic        bpp2;
    logic [6:0]  x_rep, y_rep;
    logic [8:0]  stride, start_idx;
    logic [7:0]  match_row;
    logic        blank, new_scanline, new_frame, wait_req, wait_sel;
    logic [5:0]  rgb;
    logic [8:0]  vram_idx;
    logic [7:0]  row;
    logic        row_done, row_match, stall;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] word;

    always #5 clk = ~clk;

    vga_vram_scanout dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .vram_we_i      (vram_we),
        .vram_waddr_i   (vram_waddr),
        .vram_wdata_i   (vram_wdata),
        .vram_be_i      (vram_be),
        .palette_i      (palette),
        .bpp2_i         (bpp2),
        .x_rep_i        (x_rep),
        .y_rep_i        (y_rep),
        .stride_i       (stride),
        .start_idx_i    (start_idx),
        .match_row_i    (match_row),
        .blank_i        (blank),
        .new_scanline_i (new_scanline),
        .new_frame_i    (new_frame),
        .wait_req_i     (wait_req),
        .wait_sel_i     (wait_sel),
        .rgb_o          (rgb),
        .vram_idx_o     (vram_idx),
        .row_o          (row),
        .row_done_o     (row_done),
        .row_match_o    (row_match),
        .stall_o        (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] be);
        vram_we = 1'b1; vram_waddr = addr; vram_wdata = data; vram_be = be;
        tick();
        vram_we = 1'b0;
    endtask

    task automatic frame_start();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic scanline();
        new_scanline = 1'b1;
        tick();
        new_scanline = 1'b0;
    endtask

    // Reads 32 consecutive 1bpp pixels from start_idx back through rgb (c1 = set bit).
    task automatic scan_word(output logic [31:0] w);
        w = '0;
        blank = 1'b1;
        frame_start();
        blank = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            w[i] = (rgb == C1);
        end
        blank = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; vram_we = 1'b0; vram_waddr = '0; vram_wdata = '0; vram_be = '0;
        palette = {C3, C2, C1, C0}; bpp2 = 1'b0; x_rep = 7'd0; y_rep = 7'd0;
        stride = 9'd20; start_idx = 9'd0; match_row = 8'd1; blank = 1'b1;
        new_scanline = 1'b0; new_frame = 1'b0; wait_req = 1'b0; wait_sel = 1'b0;
        tick(); tick();
        check("reset rgb", 32'(rgb), 32'd0);
        check("reset idx", 32'(vram_idx), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset row", 32'(row), 32'd0);
        rst = 1'b0;

        // Basic 1bpp scan-out of 0x5
        write_word(4'd0, 32'h0000_0005, 4'hF);
        frame_start();
        check("nf idx", 32'(vram_idx), 32'd0);
        blank = 1'b0;
        tick(); check("1bpp px0", 32'(rgb), 32'(C1));
        tick(); check("1bpp px1", 32'(rgb), 32'(C0));
        tick(); check("1bpp px2", 32'(rgb), 32'(C1));
        tick(); check("1bpp px3", 32'(rgb), 32'(C0));
        check("1bpp idx", 32'(vram_idx), 32'd4);
        blank = 1'b1;
        tick(); check("blank rgb", 32'(rgb), 32'd0);

        // Byte enables
        write_word(4'd1, 32'h1234_5678, 4'hF);
        write_word(4'd1, 32'hFFFF_FFFF, 4'b0010);
        start_idx = 9'd32;
        scan_word(word);
        check("byte en word1", word, 32'h1234_FF78);

        start_idx = 9'd400;
        frame_start();
        check("start clamp", 32'(vram_idx), 32'd0);

        // 2bpp with odd start
        write_word(4'd0, 32'h0000_0008, 4'hF);
        bpp2 = 1'b1; start_idx = 9'd3;
        frame_start();
        check("2bpp start", 32'(vram_idx), 32'd2);
        blank = 1'b0;
        tick(); check("2bpp px0", 32'(rgb), 32'(C2));
        tick(); check("2bpp px1", 32'(rgb), 32'(C0));
        check("2bpp idx", 32'(vram_idx), 32'd6);
        palette = {C3, C2, C1, 6'h3F};
        tick(); check("palette live", 32'(rgb), 32'h3F);
        palette = {C3, C2, C1, C0};
        blank = 1'b1; bpp2 = 1'b0;
        tick();

        // Row wrap, row_done/row_match, frame-latched stride
        start_idx = 9'd310; stride = 9'd20; y_rep = 7'd0; x_rep = 7'd1; match_row = 8'd1;
        frame_start();
        check("wrap start", 32'(vram_idx), 32'd310);
        blank = 1'b0;
        tick(); check("x_rep hold", 32'(vram_idx), 32'd310);
        tick(); check("x_rep step", 32'(vram_idx), 32'd311);
        blank = 1'b1; stride = 9'd40;
        scanline();
        check("row1 idx", 32'(vram_idx), 32'd10);
        check("row1 row", 32'(row), 32'd1);
        check("row1 done", 32'(row_done), 32'd1);
        check("row1 match", 32'(row_match), 32'd1);
        tick();
        check("done pulse", 32'(row_done), 32'd0);
        check("match pulse", 32'(row_match), 32'd0);
        scanline();
        check("old stride", 32'(vram_idx), 32'd30);
        check("row2 row", 32'(row), 32'd2);
        check("row2 done", 32'(row_done), 32'd1);
        check("row2 nomatch", 32'(row_match), 32'd0);

        // Pixel step wrap at end of VRAM
        stride = 9'd20; start_idx = 9'd318; x_rep = 7'd0;
        frame_start();
        blank = 1'b0;
        tick(); check("step 319", 32'(vram_idx), 32'd319);
        tick(); check("step wrap", 32'(vram_idx), 32'd0);
        blank = 1'b1;

        // y_rep = 1: first scanline repeats the row
        y_rep = 7'd1; start_idx = 9'd0; match_row = 8'd5;
        frame_start();
        scanline();
        check("yrep repeat idx", 32'(vram_idx), 32'd0);
        check("yrep no done", 32'(row_done), 32'd0);
        scanline();
        check("yrep advance", 32'(vram_idx), 32'd20);
        check("yrep row", 32'(row), 32'd1);

        // Oversized stride loads 0
        stride = 9'd400; start_idx = 9'd5; y_rep = 7'd0;
        frame_start();
        scanline();
        check("stride clamp", 32'(vram_idx), 32'd5);
        stride = 9'd20;

        // Wait sel=0 issued inside blank
        blank = 1'b1;
        wait_req = 1'b1; wait_sel = 1'b0;
        tick();
        wait_req = 1'b0;
        check("wait0 set", 32'(stall), 32'd1);
        tick(); tick(); tick();
        check("wait0 in blank", 32'(stall), 32'd1);
        blank = 1'b0;
        tick(); tick();
        check("wait0 active", 32'(stall), 32'd1);
        blank = 1'b1;
        tick();
        check("wait0 release", 32'(stall), 32'd0);

        // Wait sel=1 ignores blank edges
        wait_req = 1'b1; wait_sel = 1'b1;
        tick();
        wait_req = 1'b0;
        blank = 1'b0; tick();
        blank = 1'b1; tick();
        check("wait1 blank", 32'(stall), 32'd1);
        frame_start();
        check("wait1 release", 32'(stall), 32'd0);

        // Reset mid-line
        start_idx = 9'd0; stride = 9'd20; y_rep = 7'd0; x_rep = 7'd0;
        frame_start();
        scanline();
        blank = 1'b0; wait_req = 1'b1;
        tick();
        wait_req = 1'b0;
        check("pre-rst rgb", 32'(rgb), 32'(C0));
        check("pre-rst stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst rgb", 32'(rgb), 32'd0);
        check("rst idx", 32'(vram_idx), 32'd0);
        check("rst row", 32'(row), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        check("rst done", 32'(row_done), 32'd0);
        for (int i = 0; i < 51; i++) tick();
        check("rst x_rep hold", 32'(vram_idx), 32'd0);
        tick();
        check("rst x_rep step", 32'(vram_idx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_vram_scanout.md
Name: vga_vram_scanout

Overview:
- Parametrised VRAM scan-out engine for the TinyQV VGA peripheral family; generalises the fixed 320-pixel, 1/2-colour framebuffer logic.
- Sits between the host register decoder (VRAM writes, config) and an external VGA timing generator (blank / scanline / frame strobes); produces a registered 6-bit BBGGRR colour.
- Adds:
  - byte-enabled VRAM writes;
  - frame-latched (shadowed) config;
  - start-offset scrolling with true modulo wrap;
  - row-match interrupt;
  - a CPU stall handshake that waits for the *next* blank edge.

Parameters:
- PIXEL_COUNT, 320, VRAM size in bits; must be a multiple of 32.
- IDX_W, 9, VRAM bit-index width; must satisfy 2^IDX_W ≥ PIXEL_COUNT.
- CNT_W, 7, width of pixel repeat counters.
- WADDR_W, 4, VRAM word address width; must satisfy 2^WADDR_W ≥ PIXEL_COUNT/32.

Ports:
- clk  in  1  system clock (64 MHz nominal)
- rst  in  1  synchronous, active-high reset
- vram_we  in  1  VRAM write strobe
- vram_waddr  in  WADDR_W  32-bit word address
- vram_wdata  in  32  write data
- vram_be  in  4  byte enables; bit n writes wdata[8n+7:8n]
- palette  in  24  {c3,c2,c1,c0}, 6 bits each
- bpp2  in  1  0 = 1 bit/pixel, 1 = 2 bits/pixel
- x_rep  in  CNT_W  clocks per VRAM pixel minus 1
- y_rep  in  CNT_W  scanlines per VRAM row minus 1
- stride  in  IDX_W  bits per VRAM row
- start_idx  in  IDX_W  frame start bit index (scroll / page)
- match_row  in  8  row number for row_match
- blank  in  1  timing: outside visible area
- new_scanline  in  1  timing: 1-cycle pulse after each visible line
- new_frame  in  1  timing: 1-cycle pulse in vblank before line 0
- wait_req  in  1  1-cycle CPU wait request
- wait_sel  in  1  0 = wait for next blank rising edge, 1 = wait for frame start
- rgb  out  6  registered BBGGRR
- vram_idx  out  IDX_W  current bit index
- row  out  8  VRAM rows completed this frame
- row_done  out  1  1-cycle pulse per completed VRAM row
- row_match  out  1  1-cycle pulse when row becomes equal to match_row
- stall  out  1  high while a wait is pending; data_ready = !stall

Behaviour:

Reset:
- rgb = 0, vram_idx = 0, row = 0, row_done = 0, row_match = 0, stall = 0.
- Shadows: x_rep = 51, y_rep = 1, stride = 20, start = 0, bpp2 = 0.
- VRAM contents are not reset.

VRAM write:
- Applied on the next clock for each enabled byte.
- Writes with waddr ≥ PIXEL_COUNT/32 are ignored.

Shadow load:
- On new_frame, copy bpp2, x_rep, y_rep, stride and start_idx into the shadows.
- stride ≥ PIXEL_COUNT loads 0; start_idx ≥ PIXEL_COUNT loads 0.
- In 2bpp mode, bit 0 of stride and start is forced to 0.
- palette is not shadowed; it takes effect immediately.

Step size:
- step = 2 if shadow bpp2 else 1.

Advance rule:
- adv(a, b) = a + b − PIXEL_COUNT if a + b ≥ PIXEL_COUNT, else a + b.
- Compute in IDX_W+1 bits.

Priority (highest first): rst > new_frame > new_scanline > blank > active.
- new_frame: idx = line_base = shadow start; px = 0; py = 0; row = 0.
- new_scanline: px = 0.
  - If py == y_rep: py = 0; line_base = idx = adv(line_base, stride); row += 1 (saturating at 255); row_done pulses the next cycle.
  - Else: py += 1; idx = line_base.
- blank (no strobe): px = 0; idx held.
- active: if px == x_rep, then px = 0 and idx = adv(idx, step); else px += 1.

Colour index:
- 1bpp: {0, vram[idx]}.
- 2bpp: {vram[idx+1], vram[idx]}.

Output pipeline:
- rgb <= blank ? 0 : palette[6*ci +: 6].
- Latency is exactly 1 clock from blank/idx to rgb.

row_match:
- Pulses in the same cycle as row_done when the new row value == match_row.
- Never pulses for row 0.

Wait handshake:
- wait_req sets stall the next cycle.
- wait_sel = 0: stall clears on the first 0→1 transition of blank seen strictly after the request cycle. Already being in blank does not release it.
- wait_sel = 1: stall clears on the cycle after new_frame.
- A wait_req while stall is already high restarts the wait with the new wait_sel.
- rst clears a pending wait.

Test Plan:
- Reset → rgb = 0, stall = 0, vram_idx = 0. Write word 0 = 0x0000_0005 with be = 0xF, palette c0 = 0x10, c1 = 0x0B, x_rep = 0, stride = 20, new_frame, then blank low → rgb sequence 0x0B, 0x10, 0x0B, 0x10, each 1 clock after idx.
- Write word 1 with be = 4'b0010, wdata = 0xFFFF_FFFF → only bits 40–47 set; bits 32–39 and 48–63 unchanged.
- 2bpp, start_idx = 3 → shadow start = 2. VRAM bits 3:2 = 2'b10 → first active rgb = c2.
- start_idx = 310, stride = 20, y_rep = 0 → after the first row, idx = 10 (wraps, not 0). row_done pulses once per line. row_match with match_row = 1 pulses on the first row.
- wait_req (sel = 0) issued while blank is already high → stall stays high through that blank, clears 1 cycle after the next blank rise. sel = 1 → stall clears the cycle after new_frame.
- Change stride mid-frame → row advance still uses the old stride until the next new_frame. rst asserted mid-line → all outputs return to reset values on the next clock.
